// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared definitions for the RTC bus arbiter.
//   state_t        : arbiter FSM state encoding (2 bits)
//   GNT_*          : bit positions of each requester in the one-hot grant
//   TIMEOUT_DEF    : default WAIT-state cycle budget before aborting
//   RD_ERR_VAL_DEF : default read data returned on a timed-out transaction
package rtc_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int GNT_INIT = 2;
  localparam int GNT_WR   = 1;
  localparam int GNT_RD   = 0;

  localparam logic [11:0] TIMEOUT_DEF    = 12'h0FF;
  localparam logic [7:0]  RD_ERR_VAL_DEF = 8'hFF;

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Handshake between the arbiter and the RTC bus controller.
//   bus_start : one-cycle pulse starting a transaction   (arbiter -> ctrl)
//   bus_rw    : 1=read, 0=write                          (arbiter -> ctrl)
//   bus_addr  : RTC register address                     (arbiter -> ctrl)
//   bus_wdata : write data                               (arbiter -> ctrl)
//   bus_done  : transaction finished, bus_rdata valid    (ctrl -> arbiter)
//   bus_rdata : data read from the RTC                   (ctrl -> arbiter)
// master = arbiter side, slave = bus controller side.
interface rtc_bus_arbiter_if;

  logic       bus_start;
  logic       bus_rw;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_done;
  logic [7:0] bus_rdata;

  modport master (
    output bus_start, bus_rw, bus_addr, bus_wdata,
    input  bus_done, bus_rdata
  );

  modport slave (
    input  bus_start, bus_rw, bus_addr, bus_wdata,
    output bus_done, bus_rdata
  );

endinterface

// File: rtl/rtc_bus_arbiter_rr_pick.sv
// rtc_rr_pick: combinational requester selector.
//   init_req, wr_req, rd_req : pending requests
//   rr_last                  : last of wr/rd served (0=rd, 1=wr)
//   sel[2:0]                 : one-hot choice, [2]=init [1]=wr [0]=rd, 0 if none
// init always wins; wr and rd alternate when both are pending.
module rtc_rr_pick
  import rtc_bus_arbiter_pkg::*;
(
  input  logic       init_req,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       rr_last,
  output logic [2:0] sel
);

  always_comb begin
    sel = 3'b000;
    if (init_req) begin
      sel[GNT_INIT] = 1'b1;
    end else if (wr_req && rd_req) begin
      // Serve whichever of the two was not served last.
      if (rr_last) sel[GNT_RD] = 1'b1;
      else         sel[GNT_WR] = 1'b1;
    end else if (wr_req) begin
      sel[GNT_WR] = 1'b1;
    end else if (rd_req) begin
      sel[GNT_RD] = 1'b1;
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: shares one RTC bus controller among the init sequencer,
// the user-write path and the chrono/periodic-read path. One bus
// transaction per grant, with a timeout guard against a hung bus.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   {init,wr,rd}_req/rw/addr/wdata : requester inputs (req is a level)
//   {init,wr,rd}_done          : one-cycle completion pulse to the owner
//   rdata, err                 : result, valid while a *_done is high
//   grant[2:0]                 : one-hot owner ([2]=init [1]=wr [0]=rd)
//   timeout_err                : sticky timeout flag, cleared only by reset
//   bus                        : handshake to the bus controller (master)
module rtc_bus_arbiter
  import rtc_bus_arbiter_pkg::*;
#(
  parameter logic [11:0] TIMEOUT    = TIMEOUT_DEF,
  parameter logic [7:0]  RD_ERR_VAL = RD_ERR_VAL_DEF
) (
  input  logic       clk,
  input  logic       reset,

  input  logic       init_req,
  input  logic       init_rw,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wdata,
  input  logic       wr_req,
  input  logic       wr_rw,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_wdata,
  input  logic       rd_req,
  input  logic       rd_rw,
  input  logic [7:0] rd_addr,
  input  logic [7:0] rd_wdata,

  output logic       init_done,
  output logic       wr_done,
  output logic       rd_done,
  output logic [7:0] rdata,
  output logic       err,
  output logic [2:0] grant,
  output logic       timeout_err,

  rtc_bus_arbiter_if.master bus
);

  state_t      state;
  logic [11:0] cnt;
  logic        rr_last;
  logic [2:0]  done_r;

  logic [2:0]  pick;
  logic        pick_rw;
  logic [7:0]  pick_addr;
  logic [7:0]  pick_wdata;

  assign init_done = done_r[GNT_INIT];
  assign wr_done   = done_r[GNT_WR];
  assign rd_done   = done_r[GNT_RD];

  rtc_rr_pick u_pick (
    .init_req (init_req),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .rr_last  (rr_last),
    .sel      (pick)
  );

  // Route the chosen requester's transaction fields to the bus latches.
  always_comb begin
    pick_rw    = rd_rw;
    pick_addr  = rd_addr;
    pick_wdata = rd_wdata;
    if (pick[GNT_INIT]) begin
      pick_rw    = init_rw;
      pick_addr  = init_addr;
      pick_wdata = init_wdata;
    end else if (pick[GNT_WR]) begin
      pick_rw    = wr_rw;
      pick_addr  = wr_addr;
      pick_wdata = wr_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= 12'd0;
      rr_last       <= 1'b0;
      done_r        <= 3'b000;
      rdata         <= 8'h00;
      err           <= 1'b0;
      grant         <= 3'b000;
      timeout_err   <= 1'b0;
      bus.bus_start <= 1'b0;
      bus.bus_rw    <= 1'b0;
      bus.bus_addr  <= 8'h00;
      bus.bus_wdata <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          // Requests and their fields are only looked at here.
          if (pick != 3'b000) begin
            grant         <= pick;
            bus.bus_rw    <= pick_rw;
            bus.bus_addr  <= pick_addr;
            bus.bus_wdata <= pick_wdata;
            state         <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          bus.bus_start <= 1'b1;
          cnt           <= 12'd0;
          state         <= ST_WAIT;
        end

        ST_WAIT: begin
          bus.bus_start <= 1'b0;
          cnt           <= cnt + 12'd1;
          // bus_done is checked first so it wins a tie with the timeout.
          if (bus.bus_done) begin
            rdata  <= bus.bus_rw ? bus.bus_rdata : 8'h00;
            err    <= 1'b0;
            done_r <= grant;
            state  <= ST_RELEASE;
          end else if (cnt == TIMEOUT - 12'd1) begin
            rdata       <= RD_ERR_VAL;
            err         <= 1'b1;
            timeout_err <= 1'b1;
            done_r      <= grant;
            state       <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (grant[GNT_WR]) rr_last <= 1'b1;
          if (grant[GNT_RD]) rr_last <= 1'b0;
          done_r <= 3'b000;
          rdata  <= 8'h00;
          err    <= 1'b0;
          grant  <= 3'b000;
          cnt    <= 12'd0;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: drives requesters and plays the bus
// controller, comparing outputs against hand-computed values.
module tb_rtc_bus_arbiter;

  localparam int TO = 255;

  logic       clk;
  logic       reset;
  logic       init_req, init_rw, wr_req, wr_rw, rd_req, rd_rw;
  logic [7:0] init_addr, init_wdata, wr_addr, wr_wdata, rd_addr, rd_wdata;
  logic       init_done, wr_done, rd_done, err, timeout_err;
  logic [7:0] rdata;
  logic [2:0] grant;

  int n_chk = 0;
  int n_err = 0;
  int lat;

  rtc_bus_arbiter_if bif ();

  rtc_bus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .init_req    (init_req),
    .init_rw     (init_rw),
    .init_addr   (init_addr),
    .init_wdata  (init_wdata),
    .wr_req      (wr_req),
    .wr_rw       (wr_rw),
    .wr_addr     (wr_addr),
    .wr_wdata    (wr_wdata),
    .rd_req      (rd_req),
    .rd_rw       (rd_rw),
    .rd_addr     (rd_addr),
    .rd_wdata    (rd_wdata),
    .init_done   (init_done),
    .wr_done     (wr_done),
    .rd_done     (rd_done),
    .rdata       (rdata),
    .err         (err),
    .grant       (grant),
    .timeout_err (timeout_err),
    .bus         (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for bus_start, then check the owner and latched address.
  task automatic wait_start(input string tag, input logic [2:0] eg,
                            input logic [7:0] ea, output int l);
    l = 0;
    while (bif.bus_start !== 1'b1 && l < 20) begin
      tick();
      l++;
    end
    chk({tag, "_start"}, 32'(bif.bus_start), 32'd1);
    chk({tag, "_gnt"},   32'(grant),         32'(eg));
    chk({tag, "_addr"},  32'(bif.bus_addr),  32'(ea));
  endtask

  // From the bus_start cycle, answer bus_done dly cycles later and check
  // the completion pulse that follows.
  task automatic finish(input string tag, input int dly, input logic [7:0] rv,
                        input logic [2:0] eg, input logic [7:0] erd);
    for (int i = 0; i < dly; i++) begin
      tick();
      if (i == 0) chk({tag, "_pulse"}, 32'(bif.bus_start), 32'd0);
    end
    bif.bus_done  = 1'b1;
    bif.bus_rdata = rv;
    tick();
    bif.bus_done  = 1'b0;
    bif.bus_rdata = 8'h00;
    chk({tag, "_done"},  32'({init_done, wr_done, rd_done}), 32'(eg));
    chk({tag, "_rdata"}, 32'(rdata), 32'(erd));
    chk({tag, "_err"},   32'(err),   32'd0);
    chk({tag, "_hold"},  32'(grant), 32'(eg));
  endtask

  initial begin
    reset = 1'b0;
    {init_req, init_rw, wr_req, wr_rw, rd_req, rd_rw} = '0;
    {init_addr, init_wdata, wr_addr, wr_wdata, rd_addr, rd_wdata} = '0;
    bif.bus_done  = 1'b0;
    bif.bus_rdata = 8'h00;

    // Reset state
    tick();
    tick();
    chk("rst_gnt",   32'(grant), 32'd0);
    chk("rst_start", 32'(bif.bus_start), 32'd0);
    chk("rst_bus",   32'({bif.bus_rw, bif.bus_addr, bif.bus_wdata}), 32'd0);
    chk("rst_out",   32'({init_done, wr_done, rd_done, err, timeout_err, rdata}), 32'd0);
    reset = 1'b1;
    tick();

    // 1: init write, bus_done 4 cycles after bus_start
    init_req = 1'b1; init_rw = 1'b0; init_addr = 8'h02; init_wdata = 8'h08;
    tick();
    chk("t1_gnt_issue", 32'(grant), 32'b100);
    init_addr = 8'h7F;  // must not leak into the latched address
    wait_start("t1", 3'b100, 8'h02, lat);
    chk("t1_lat",   32'(lat + 1), 32'd2);
    chk("t1_wdata", 32'(bif.bus_wdata), 32'h08);
    chk("t1_rw",    32'(bif.bus_rw), 32'd0);
    finish("t1", 4, 8'hAA, 3'b100, 8'h00);
    init_req = 1'b0;
    tick();
    chk("t1_onecyc", 32'({init_done, wr_done, rd_done}), 32'd0);
    chk("t1_idle",   32'(grant), 32'd0);

    // bus_done in IDLE is ignored
    bif.bus_done = 1'b1; bif.bus_rdata = 8'h77;
    tick();
    bif.bus_done = 1'b0;
    tick();
    chk("idle_bdone", 32'({init_done, wr_done, rd_done, grant}), 32'd0);

    // 2: wr and rd both held -> wr, rd, wr, rd
    wr_req = 1'b1; wr_rw = 1'b0; wr_addr = 8'h10; wr_wdata = 8'h11;
    rd_req = 1'b1; rd_rw = 1'b1; rd_addr = 8'h20;
    wait_start("t2a", 3'b010, 8'h10, lat);
    finish("t2a", 1, 8'h00, 3'b010, 8'h00);
    wait_start("t2b", 3'b001, 8'h20, lat);
    chk("t2b_lat", 32'(lat), 32'd3);
    finish("t2b", 2, 8'h5A, 3'b001, 8'h5A);
    wait_start("t2c", 3'b010, 8'h10, lat);
    finish("t2c", 0, 8'h00, 3'b010, 8'h00);
    wait_start("t2d", 3'b001, 8'h20, lat);
    finish("t2d", 3, 8'hC3, 3'b001, 8'hC3);
    wr_req = 1'b0; rd_req = 1'b0;
    tick();
    chk("t2_end", 32'({init_done, wr_done, rd_done, grant}), 32'd0);

    // 3: init arrives while wr is in WAIT; rd pending too
    wr_req = 1'b1; rd_req = 1'b1;
    wait_start("t3a", 3'b010, 8'h10, lat);
    init_req = 1'b1; init_rw = 1'b1; init_addr = 8'h05;
    finish("t3a", 2, 8'h00, 3'b010, 8'h00);
    wr_req = 1'b0;
    wait_start("t3b", 3'b100, 8'h05, lat);
    finish("t3b", 1, 8'h33, 3'b100, 8'h33);
    init_req = 1'b0;
    wait_start("t3c", 3'b001, 8'h20, lat);
    finish("t3c", 1, 8'h44, 3'b001, 8'h44);
    rd_req = 1'b0;
    tick();
    chk("t4_pre_sticky", 32'(timeout_err), 32'd0);

    // 4: read with no bus_done -> timeout
    rd_req = 1'b1; rd_addr = 8'h21;
    wait_start("t4", 3'b001, 8'h21, lat);
    repeat (TO - 1) tick();
    chk("t4_early", 32'({rd_done, err}), 32'd0);
    tick();
    chk("t4_done",   32'(rd_done), 32'd1);
    chk("t4_rdata",  32'(rdata), 32'hFF);
    chk("t4_err",    32'(err), 32'd1);
    chk("t4_sticky", 32'(timeout_err), 32'd1);
    rd_req = 1'b0;
    tick();
    chk("t4_errclr", 32'(err), 32'd0);
    wr_req = 1'b1;
    wait_start("t4w", 3'b010, 8'h10, lat);
    finish("t4w", 1, 8'h00, 3'b010, 8'h00);
    wr_req = 1'b0;
    chk("t4_sticky2", 32'(timeout_err), 32'd1);
    tick();

    // 5: bus_done in the same cycle the counter hits TIMEOUT
    rd_req = 1'b1; rd_addr = 8'h30;
    wait_start("t5", 3'b001, 8'h30, lat);
    finish("t5", TO - 1, 8'h59, 3'b001, 8'h59);
    rd_req = 1'b0;
    chk("t5_sticky", 32'(timeout_err), 32'd1);
    tick();

    // 6: reset during WAIT
    rd_req = 1'b1; rd_addr = 8'h31;
    wait_start("t6", 3'b001, 8'h31, lat);
    tick();
    tick();
    #3 reset = 1'b0;
    #1;
    chk("t6_gnt",  32'(grant), 32'd0);
    chk("t6_bus",  32'({bif.bus_start, bif.bus_rw, bif.bus_addr, bif.bus_wdata}), 32'd0);
    chk("t6_out",  32'({init_done, wr_done, rd_done, err, timeout_err, rdata}), 32'd0);
    tick();
    tick();
    chk("t6_nodone", 32'({init_done, wr_done, rd_done}), 32'd0);
    reset = 1'b1;
    wait_start("t6r", 3'b001, 8'h31, lat);
    chk("t6r_lat", 32'(lat), 32'd2);
    finish("t6r", 2, 8'h66, 3'b001, 8'h66);
    rd_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Shares the single RTC bus controller (address/data strobe engine) among three requesters: the power-up init sequencer, the user-write path, and the chrono/periodic-read path.
- Grants one requester at a time and issues exactly one bus transaction per grant, using a start/done handshake.
- Returns read data and a one-cycle completion pulse to the winning requester.
- Guards against a hung bus with a timeout.

Parameters:
- TIMEOUT, 12'h0FF: cycles to wait in WAIT for bus_done before aborting the transaction.
- RD_ERR_VAL, 8'hFF: value returned on rdata when a transaction times out.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- init_req, wr_req, rd_req  in  1 each  transaction request; level, held until the matching done pulse
- init_rw, wr_rw, rd_rw  in  1 each  1=read, 0=write
- init_addr, wr_addr, rd_addr  in  8 each  RTC register address
- init_wdata, wr_wdata, rd_wdata  in  8 each  write data
- init_done, wr_done, rd_done  out  1 each  one-cycle completion pulse to the owner
- rdata  out  8  read data, valid while any *_done is high
- err  out  1  high with the done pulse when the transaction timed out
- grant  out  3  one-hot owner: [2]=init, [1]=wr, [0]=rd; 0 when idle
- bus_start  out  1  one-cycle pulse starting a bus transaction
- bus_rw  out  1  latched rw of the owner
- bus_addr  out  8  latched address of the owner
- bus_wdata  out  8  latched write data of the owner
- bus_done  in  1  bus controller finished; bus_rdata valid this cycle
- bus_rdata  in  8  data read from the RTC
- timeout_err  out  1  sticky flag, set on any timeout

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE.
  - All outputs 0: grant, bus_start, bus_rw, bus_addr, bus_wdata, rdata, err, all *_done, timeout_err.
  - Timeout counter 0; rr_last=0.
  - Reset asserted mid-transaction aborts it silently; no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT, RELEASE.
- IDLE:
  - init_req has absolute priority.
  - Otherwise wr_req and rd_req are served round-robin: rr_last records the last of the two served (0=rd, 1=wr). If both are pending, serve the other one.
  - On selection: set grant; latch rw/addr/wdata into bus_* registers; go to ISSUE next cycle.
  - No requests: stay in IDLE, grant=0.
- ISSUE:
  - bus_start=1 for exactly one cycle; go to WAIT.
  - Latency from req high (bus idle) to bus_start is 2 cycles.
- WAIT:
  - Counter increments each cycle.
  - bus_done=1: capture bus_rdata (on writes, 8'h00), err=0, go to RELEASE.
  - Counter reaches TIMEOUT before bus_done: rdata=RD_ERR_VAL, err=1, timeout_err<=1, go to RELEASE.
  - bus_done and timeout in the same cycle: bus_done wins (err=0).
- RELEASE:
  - Owner's *_done=1 with rdata/err valid for exactly one cycle.
  - Update rr_last if the owner was wr or rd.
  - grant is cleared; counter cleared; return to IDLE.
- Re-arbitration:
  - The earliest new bus_start is 3 cycles after a done pulse.
  - A requester still asserting req in the cycle after its done is treated as a new transaction. This allows the init sequencer to chain its register list back to back.
- Requester drops req during ISSUE/WAIT: the transaction still completes and the done pulse is still issued.
- Request inputs are sampled only in IDLE; changes to addr/data after grant are ignored.
- bus_done outside WAIT is ignored.
- grant stays stable from ISSUE through RELEASE.
- timeout_err is cleared only by reset.

Decomposition:
- Shared package:
  - FSM state encoding (2 bits).
  - Grant index constants GNT_INIT=2, GNT_WR=1, GNT_RD=0.
  - Default TIMEOUT and RD_ERR_VAL.
- Natural sub-module: rtc_rr_pick.
  - Combinational priority / round-robin selector.
  - Inputs: three reqs and rr_last. Output: one-hot select.
- Remaining logic in the top module: FSM, latches, timeout counter.

Test Plan:
1. Release reset; init_req=1, init_rw=0, init_addr=8'h02, init_wdata=8'h08; bus_done 4 cycles after bus_start -> bus_start pulses with bus_addr=02, bus_wdata=08; init_done one cycle; grant=3'b100 throughout.
2. wr_req and rd_req asserted together, both held across 4 transactions -> grant order wr, rd, wr, rd (rr_last=0 after reset); each issues one bus_start.
3. init_req rises while a wr transaction is in WAIT -> wr completes and wr_done pulses; the next grant is init even though rd_req is pending.
4. rd_req, rd_addr=8'h21; bus_done never asserted -> after TIMEOUT cycles rd_done=1, rdata=8'hFF, err=1; timeout_err stays 1 through later good transactions.
5. rd transaction; bus_done with bus_rdata=8'h59 in the same cycle the counter hits TIMEOUT -> rdata=8'h59, err=0, timeout_err unchanged.
6. Assert reset during WAIT -> all outputs 0 immediately; no done pulse; after release a pending req is re-arbitrated normally.
